// File: rtl/bitstream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_pkg
// Description : Shared constants and helpers for the bitstream fetch block.
//               Holds the FSM state encoding and the words-per-block math.
// Revision    : 1.0 - initial release
// ============================================================================
package bitstream_pkg;

    // FSM state encoding, 3 bits wide
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CHECK = 3'd1;
    localparam logic [2:0] c_ST_READ  = 3'd2;
    localparam logic [2:0] c_ST_CAPT  = 3'd3;
    localparam logic [2:0] c_ST_OUT   = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    // Number of memory words packed into one AES block
    function automatic int calc_wpb(input int aes_w, input int data_w);
        return aes_w / data_w;
    endfunction

    // True when an AES block is a whole, non-zero number of memory words
    function automatic bit width_ok(input int aes_w, input int data_w);
        return (data_w > 0) && (aes_w >= data_w) && ((aes_w % data_w) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_assembler.sv
`default_nettype none
// ============================================================================
// Module      : block_assembler
// Description : WPB-deep word shift register that packs memory words into
//               one AES block MSB-first, plus a word counter with full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module block_assembler
    import bitstream_pkg::*;
#(
    parameter int DATA_LENGTH     = 32,
    parameter int AES_DATA_LENGTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_shift,
    input  logic                       i_clr_cnt,
    input  logic [DATA_LENGTH-1:0]     i_word,
    output logic [AES_DATA_LENGTH-1:0] o_block,
    output logic                       o_last,
    output logic                       o_full
);

    localparam int c_WPB   = calc_wpb(AES_DATA_LENGTH, DATA_LENGTH);
    localparam int c_CNT_W = $clog2(c_WPB + 1);

    logic [AES_DATA_LENGTH-1:0] r_block;
    logic [c_CNT_W-1:0]         r_cnt;

    // Shift new words in at the bottom so the first word ends up on top
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_block <= '0;
        end else if (i_shift) begin
            r_block <= (r_block << DATA_LENGTH) | AES_DATA_LENGTH'(i_word);
        end
    end

    // Count words captured into the current block
    always_ff @(posedge clk) begin
        if (rst || i_clear || i_clr_cnt) begin
            r_cnt <= '0;
        end else if (i_shift) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_block = r_block;
    assign o_last  = (r_cnt == c_CNT_W'(c_WPB - 1));
    assign o_full  = (r_cnt == c_CNT_W'(c_WPB));

endmodule
`default_nettype wire

// File: rtl/bitstream_fetch.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_fetch
// Description : Reads the encrypted bitstream from configuration memory,
//               packs words into AES blocks and streams them to the decrypt
//               stage over valid/ready. Rejects ranges past the address space.
// Revision    : 1.0 - initial release
// ============================================================================
module bitstream_fetch
    import bitstream_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_LENGTH     = 32,
    parameter int AES_DATA_LENGTH = 128
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start_i,
    input  logic [ADDR_WIDTH-1:0]      base_addr_i,
    input  logic [DATA_LENGTH-1:0]     block_cnt_i,
    output logic                       mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    input  logic [DATA_LENGTH-1:0]     mem_rdata_i,
    output logic                       blk_valid_o,
    output logic [AES_DATA_LENGTH-1:0] blk_data_o,
    input  logic                       blk_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int c_WPB   = calc_wpb(AES_DATA_LENGTH, DATA_LENGTH);
    // Wide enough that base + count*WPB can never truncate
    localparam int c_CHK_W = ADDR_WIDTH + DATA_LENGTH + $clog2(c_WPB) + 1;

    generate
        if (!width_ok(AES_DATA_LENGTH, DATA_LENGTH)) begin : g_width_check
            $error("AES_DATA_LENGTH must be a non-zero multiple of DATA_LENGTH");
        end
    endgenerate

    logic [2:0]                 r_state;
    logic [2:0]                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [ADDR_WIDTH-1:0]      r_addr_hold;
    logic [DATA_LENGTH-1:0]     r_remaining;
    logic                       r_err;

    logic                       w_latch;
    logic                       w_shift;
    logic                       w_handshake;
    logic                       w_set_err;
    logic                       w_last;
    logic                       w_full;
    logic                       w_overflow;
    logic [c_CHK_W-1:0]         w_end_addr;
    logic [AES_DATA_LENGTH-1:0] w_block;

    // One past the last word the fetch would touch, checked against 2^ADDR_WIDTH
    assign w_end_addr = c_CHK_W'(r_addr) + c_CHK_W'(r_remaining) * c_CHK_W'(c_WPB);
    assign w_overflow = (w_end_addr > (c_CHK_W'(1) << ADDR_WIDTH));

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_shift     = 1'b0;
        w_handshake = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = c_ST_CHECK;
                end
            end
            c_ST_CHECK: begin
                if (r_remaining == '0) begin
                    w_state_nxt = c_ST_DONE;
                end else if (w_overflow) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_state_nxt = c_ST_CAPT;
            end
            c_ST_CAPT: begin
                w_shift     = 1'b1;
                w_state_nxt = w_last ? c_ST_OUT : c_ST_READ;
            end
            c_ST_OUT: begin
                if (w_full && blk_ready_i) begin
                    w_handshake = 1'b1;
                    w_state_nxt = (r_remaining == DATA_LENGTH'(1)) ? c_ST_DONE : c_ST_READ;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Address, remaining-block count and sticky error flag
    always_ff @(posedge clk) begin
        if (clr) begin
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_latch) begin
                r_addr      <= base_addr_i;
                r_remaining <= block_cnt_i;
                r_err       <= 1'b0;
            end else if (w_shift) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            // Keep the last issued address visible once the strobe drops
            if (r_state == c_ST_READ) begin
                r_addr_hold <= r_addr;
            end
            if (w_handshake) begin
                r_remaining <= r_remaining - DATA_LENGTH'(1);
            end
        end
    end

    block_assembler #(
        .DATA_LENGTH     (DATA_LENGTH),
        .AES_DATA_LENGTH (AES_DATA_LENGTH)
    ) u_block_assembler (
        .clk       (clk),
        .rst       (clr),
        .i_clear   (w_latch),
        .i_shift   (w_shift),
        .i_clr_cnt (w_handshake),
        .i_word    (mem_rdata_i),
        .o_block   (w_block),
        .o_last    (w_last),
        .o_full    (w_full)
    );

    assign mem_rd_en_o = (r_state == c_ST_READ);
    assign mem_addr_o  = (r_state == c_ST_READ) ? r_addr : r_addr_hold;
    assign blk_valid_o = (r_state == c_ST_OUT) && w_full;
    assign blk_data_o  = w_block;
    assign busy_o      = (r_state != c_ST_IDLE);
    assign done_o      = (r_state == c_ST_DONE);
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitstream_fetch
// Description : Directed self-checking bench for bitstream_fetch. Memory
//               model returns each word's own address as its data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitstream_fetch;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         start_i = 1'b0;
    logic [7:0]   base_addr_i = '0;
    logic [31:0]  block_cnt_i = '0;
    logic         mem_rd_en_o;
    logic [7:0]   mem_addr_o;
    logic [31:0]  mem_rdata_i = '0;
    logic         blk_valid_o;
    logic [127:0] blk_data_o;
    logic         blk_ready_i = 1'b1;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;

    // Monitor state
    int           cyc = 0;
    int           t0 = 0;
    bit           arm = 1'b0;
    int           n_rd, n_done, n_valid, first_rd_t, first_valid_t, done_t;
    logic [7:0]   last_rd_addr;
    logic [127:0] blk_q[$];

    bitstream_fetch u_dut (
        .clk         (clk),
        .clr         (clr),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .block_cnt_i (block_cnt_i),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .blk_valid_o (blk_valid_o),
        .blk_data_o  (blk_data_o),
        .blk_ready_i (blk_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Memory: word content equals its address, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rdata_i <= {24'h0, mem_addr_o};
    end

    // Observe outputs mid-cycle and log events relative to the start cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (arm && start_i) begin
            t0  = cyc;
            arm = 1'b0;
        end
        if (mem_rd_en_o) begin
            n_rd = n_rd + 1;
            last_rd_addr = mem_addr_o;
            if (first_rd_t < 0) first_rd_t = cyc - t0;
        end
        if (blk_valid_o) begin
            n_valid = n_valid + 1;
            if (first_valid_t < 0) first_valid_t = cyc - t0;
            if (blk_ready_i) blk_q.push_back(blk_data_o);
        end
        if (done_o) begin
            n_done = n_done + 1;
            done_t = cyc - t0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_reset();
        n_rd = 0; n_done = 0; n_valid = 0;
        first_rd_t = -1; first_valid_t = -1; done_t = -1;
        last_rd_addr = '0;
        blk_q.delete();
    endtask

    task automatic start_fetch(input logic [7:0] base, input logic [31:0] cnt);
        mon_reset();
        base_addr_i = base;
        block_cnt_i = cnt;
        arm = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done != 0) break;
            tick();
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_rd_en_o, blk_valid_o, busy_o, done_o, err_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {mem_rd_en_o, blk_valid_o, busy_o, done_o, err_o});
        end
        checks++;
        if (mem_addr_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h want 00", mem_addr_o);
        end
        checks++;
        if (blk_data_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", blk_data_o);
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        blk_ready_i = 1'b1;
        start_fetch(8'h10, 32'd2);
        wait_done("basic", 60);
        checks++;
        if (first_rd_t !== 2) begin
            errors++; $display("FAIL basic_first_read: got %0d want 2", first_rd_t);
        end
        checks++;
        if (first_valid_t !== 10) begin
            errors++; $display("FAIL basic_first_valid: got %0d want 10", first_valid_t);
        end
        checks++;
        if (n_rd !== 8) begin
            errors++; $display("FAIL basic_nreads: got %0d want 8", n_rd);
        end
        checks++;
        if (blk_q.size() !== 2) begin
            errors++; $display("FAIL basic_nblocks: got %0d want 2", blk_q.size());
        end else begin
            checks++;
            if (blk_q[0] !== 128'h00000010_00000011_00000012_00000013) begin
                errors++; $display("FAIL basic_blk0: got %h want 00000010000000110000001200000013", blk_q[0]);
            end
            checks++;
            if (blk_q[1] !== 128'h00000014_00000015_00000016_00000017) begin
                errors++; $display("FAIL basic_blk1: got %h want 00000014000000150000001600000017", blk_q[1]);
            end
        end
        tick();
        checks++;
        if (n_done !== 1 || done_t !== 20) begin
            errors++; $display("FAIL basic_done: got count %0d at %0d want 1 at 20", n_done, done_t);
        end
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy %b err %b want 0 0", busy_o, err_o);
        end
    endtask

    task automatic test_zero_cnt();
        start_fetch(8'h10, 32'd0);
        wait_done("zero", 20);
        repeat (3) tick();
        checks++;
        if (done_t !== 2 || n_done !== 1) begin
            errors++; $display("FAIL zero_done: got count %0d at %0d want 1 at 2", n_done, done_t);
        end
        checks++;
        if (n_rd !== 0 || n_valid !== 0 || err_o !== 1'b0) begin
            errors++; $display("FAIL zero_quiet: got rd %0d valid %0d err %b want 0 0 0", n_rd, n_valid, err_o);
        end
    endtask

    task automatic test_overflow();
        start_fetch(8'hFC, 32'd2);
        wait_done("ovf", 20);
        repeat (3) tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL ovf_err: got %b want 1", err_o);
        end
        checks++;
        if (n_rd !== 0 || n_valid !== 0 || done_t !== 2) begin
            errors++; $display("FAIL ovf_quiet: got rd %0d valid %0d done_t %0d want 0 0 2", n_rd, n_valid, done_t);
        end
    endtask

    task automatic test_top_of_range();
        start_fetch(8'hF8, 32'd2);
        wait_done("edge", 60);
        checks++;
        if (n_rd !== 8 || last_rd_addr !== 8'hFF) begin
            errors++; $display("FAIL edge_reads: got %0d last %h want 8 last ff", n_rd, last_rd_addr);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL edge_err: got %b want 0", err_o);
        end
        checks++;
        if (blk_q.size() !== 2) begin
            errors++; $display("FAIL edge_nblocks: got %0d want 2", blk_q.size());
        end else begin
            checks++;
            if (blk_q[1] !== 128'h000000FC_000000FD_000000FE_000000FF) begin
                errors++; $display("FAIL edge_blk1: got %h want 000000fc000000fd000000fe000000ff", blk_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_blk;
        exp_blk = 128'h00000000_00000001_00000002_00000003;
        blk_ready_i = 1'b0;
        start_fetch(8'h00, 32'd1);
        for (int i = 0; i < 30; i++) begin
            if (blk_valid_o) break;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (blk_valid_o !== 1'b1 || blk_data_o !== exp_blk) begin
                errors++; $display("FAIL bp_hold%0d: got valid %b data %h want 1 %h", i, blk_valid_o, blk_data_o, exp_blk);
            end
            tick();
        end
        blk_ready_i = 1'b1;
        checks++;
        if (blk_valid_o !== 1'b1 || blk_data_o !== exp_blk) begin
            errors++; $display("FAIL bp_accept: got valid %b data %h want 1 %h", blk_valid_o, blk_data_o, exp_blk);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || blk_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_done: got done %b valid %b want 1 0", done_o, blk_valid_o);
        end
        checks++;
        if (first_valid_t !== 10) begin
            errors++; $display("FAIL bp_first_valid: got %0d want 10", first_valid_t);
        end
        tick();
    endtask

    task automatic test_clr_mid();
        blk_ready_i = 1'b1;
        start_fetch(8'h40, 32'd2);
        repeat (6) tick();  // now in cycle 7: third CAPT of the first block
        checks++;
        if (busy_o !== 1'b1 || mem_rd_en_o !== 1'b0) begin
            errors++; $display("FAIL clr_pre: got busy %b rd %b want 1 0", busy_o, mem_rd_en_o);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({mem_rd_en_o, blk_valid_o, busy_o, done_o, err_o} !== 5'b0 || mem_addr_o !== 8'h00 || blk_data_o !== 128'h0) begin
            errors++; $display("FAIL clr_outputs: got flags %b addr %h data %h want 0",
                               {mem_rd_en_o, blk_valid_o, busy_o, done_o, err_o}, mem_addr_o, blk_data_o);
        end
        mon_reset();
        repeat (20) tick();
        checks++;
        if (n_rd !== 0 || n_valid !== 0 || n_done !== 0) begin
            errors++; $display("FAIL clr_quiet: got rd %0d valid %0d done %0d want 0 0 0", n_rd, n_valid, n_done);
        end
        start_fetch(8'h20, 32'd1);
        wait_done("clr_restart", 40);
        checks++;
        if (n_rd !== 4 || done_t !== 11) begin
            errors++; $display("FAIL clr_restart_timing: got rd %0d done_t %0d want 4 11", n_rd, done_t);
        end
        checks++;
        if (blk_q.size() !== 1) begin
            errors++; $display("FAIL clr_restart_nblocks: got %0d want 1", blk_q.size());
        end else begin
            checks++;
            if (blk_q[0] !== 128'h00000020_00000021_00000022_00000023) begin
                errors++; $display("FAIL clr_restart_blk: got %h want 00000020000000210000002200000023", blk_q[0]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        blk_ready_i = 1'b1;
        start_fetch(8'h30, 32'd2);
        repeat (4) tick();
        base_addr_i = 8'h80;
        block_cnt_i = 32'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done("restart", 60);
        tick();
        checks++;
        if (n_rd !== 8 || last_rd_addr !== 8'h37 || done_t !== 20 || n_done !== 1) begin
            errors++; $display("FAIL restart_run: got rd %0d last %h done_t %0d ndone %0d want 8 37 20 1",
                               n_rd, last_rd_addr, done_t, n_done);
        end
        checks++;
        if (blk_q.size() !== 2) begin
            errors++; $display("FAIL restart_nblocks: got %0d want 2", blk_q.size());
        end else begin
            checks++;
            if (blk_q[0] !== 128'h00000030_00000031_00000032_00000033 ||
                blk_q[1] !== 128'h00000034_00000035_00000036_00000037) begin
                errors++; $display("FAIL restart_blks: got %h %h want 00000030..33 00000034..37", blk_q[0], blk_q[1]);
            end
        end
    endtask

    initial begin
        mon_reset();
        test_reset();
        test_basic();
        test_zero_cnt();
        test_overflow();
        test_top_of_range();
        test_backpressure();
        test_clr_mid();
        test_restart_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
